// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_fwd_select.sv
// Forwarding source selection for one EX operand, based on the EX and MEM producers.
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_en,
  input  logic [4:0] i_exDest,
  input  logic       i_exRegWrite,
  input  logic       i_exReadEn,
  input  logic [4:0] i_memDest,
  input  logic       i_memRegWrite,
  output logic [1:0] o_sel
);

  logic w_exHit;
  logic w_memHit;

  // A load still in EX has no data yet; that case is covered by the stall path.
  assign w_exHit  = i_en & i_exRegWrite & ~i_exReadEn &
                    (i_exDest != REG_ZERO) & (i_exDest == i_src);
  assign w_memHit = i_en & i_memRegWrite &
                    (i_memDest != REG_ZERO) & (i_memDest == i_src);

  always_comb begin
    o_sel = FWD_RF;
    if (w_exHit)
      o_sel = FWD_MEM;
    else if (w_memHit)
      o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: registered forwarding selects, load-use stall FSM, branch flush.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_dest,
  input  logic             ex_RegWrite,
  input  logic             ex_read_en,
  input  logic [4:0]       mem_dest,
  input  logic             mem_RegWrite,
  input  logic             mem_branch,
  input  logic             mem_zero,
  output logic [1:0]       FA,
  output logic [1:0]       FB,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             idex_bubble,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             flush_exmem,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [2:0] LAT_M1 = 3'(LOAD_LAT - 1);

  state_t     r_state;
  state_t     w_nextState;
  logic [2:0] r_cnt;
  logic [2:0] w_nextCnt;
  logic       w_stall;
  logic       w_branch;
  logic       w_loadUse;
  logic [1:0] w_selA;
  logic [1:0] w_selB;
  logic [1:0] r_fa;
  logic [1:0] r_fb;

  assign w_branch  = mem_branch & mem_zero & ~reset;
  assign w_loadUse = ex_read_en & ex_RegWrite & (ex_dest != REG_ZERO) &
                     ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

  fwd_select u_fwdA (
    .i_src         (id_rs),
    .i_en          (1'b1),
    .i_exDest      (ex_dest),
    .i_exRegWrite  (ex_RegWrite),
    .i_exReadEn    (ex_read_en),
    .i_memDest     (mem_dest),
    .i_memRegWrite (mem_RegWrite),
    .o_sel         (w_selA)
  );

  fwd_select u_fwdB (
    .i_src         (id_rt),
    .i_en          (id_uses_rt),
    .i_exDest      (ex_dest),
    .i_exRegWrite  (ex_RegWrite),
    .i_exReadEn    (ex_read_en),
    .i_memDest     (mem_dest),
    .i_memRegWrite (mem_RegWrite),
    .o_sel         (w_selB)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
    end
  end

  // The RUN cycle that detects the hazard is the first bubble; STALL adds LOAD_LAT-1 more.
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_stall     = 1'b0;
    if (w_branch) begin
      w_nextState = RUN;
      w_nextCnt   = 3'd0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_loadUse) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_nextState = STALL;
              w_nextCnt   = LAT_M1;
            end
          end
        end
        STALL: begin
          w_stall = 1'b1;
          if (r_cnt <= 3'd1) begin
            w_nextState = RUN;
            w_nextCnt   = 3'd0;
          end else begin
            w_nextCnt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_nextState = RUN;
          w_nextCnt   = 3'd0;
        end
      endcase
    end
    if (reset)
      w_stall = 1'b0;
  end

  assign pc_write_en   = ~w_stall;
  assign ifid_write_en = ~w_stall;
  assign idex_bubble   = w_stall;
  assign flush_ifid    = w_branch;
  assign flush_idex    = w_branch;
  assign flush_exmem   = w_branch;

  // Selects follow the instruction entering EX, so a bubble or squash clears them.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fa <= FWD_RF;
      r_fb <= FWD_RF;
    end else if (w_stall | w_branch) begin
      r_fa <= FWD_RF;
      r_fb <= FWD_RF;
    end else begin
      r_fa <= w_selA;
      r_fb <= w_selB;
    end
  end

  assign FA = r_fa;
  assign FB = r_fb;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] r_stallCnt;
  logic [CNT_W-1:0] r_flushCnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall && (r_stallCnt != {CNT_W{1'b1}}))
        r_stallCnt <= r_stallCnt + 1'b1;
      if (w_branch && (r_flushCnt != {CNT_W{1'b1}}))
        r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share one stimulus table.
module tb_hazard_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_dest, mem_dest;
  logic       id_uses_rt, ex_RegWrite, ex_read_en, mem_RegWrite, mem_branch, mem_zero;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        pc1, ifid1, bub1, fi1, fe1, fx1;
  logic        pc3, ifid3, bub3, fi3, fe3, fx3;
  logic [15:0] sc1, fc1;
  logic [3:0]  sc3, fc3;

  always #5 clock = ~clock;

  hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_RegWrite(ex_RegWrite), .ex_read_en(ex_read_en),
    .mem_dest(mem_dest), .mem_RegWrite(mem_RegWrite), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .FA(fa1), .FB(fb1), .pc_write_en(pc1), .ifid_write_en(ifid1), .idex_bubble(bub1),
    .flush_ifid(fi1), .flush_idex(fe1), .flush_exmem(fx1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_ctrl #(.LOAD_LAT(3), .CNT_W(4)) dut3 (
    .clock(clock), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_dest(ex_dest), .ex_RegWrite(ex_RegWrite), .ex_read_en(ex_read_en),
    .mem_dest(mem_dest), .mem_RegWrite(mem_RegWrite), .mem_branch(mem_branch), .mem_zero(mem_zero),
    .FA(fa3), .FB(fb3), .pc_write_en(pc3), .ifid_write_en(ifid3), .idex_bubble(bub3),
    .flush_ifid(fi3), .flush_idex(fe3), .flush_exmem(fx3), .stall_cnt(sc3), .flush_cnt(fc3)
  );

  typedef struct {
    logic       rst, chk;
    logic [4:0] rs, rt;
    logic       ur;
    logic [4:0] exD;
    logic       exRw, exRd;
    logic [4:0] memD;
    logic       memRw, br, z;
    logic       st1, st3, fl;
    logic [1:0] fa1, fb1, fa3, fb3;
  } vec_t;

  typedef struct {
    logic [1:0] fa1, fb1, fa3, fb3;
  } fwd_t;

  vec_t vecs[$];
  fwd_t sb[$];
  int   compared = 0;
  int   mismatched = 0;
  int   expSc1 = 0, expSc3 = 0, expFc1 = 0, expFc3 = 0;

  function automatic vec_t mk(input int rst, chk, rs, rt, ur, exD, exRw, exRd, memD, memRw,
                              br, z, st1, st3, fl, fa1, fb1, fa3, fb3);
    vec_t v;
    v.rst = 1'(rst);   v.chk = 1'(chk);
    v.rs = 5'(rs);     v.rt = 5'(rt);     v.ur = 1'(ur);
    v.exD = 5'(exD);   v.exRw = 1'(exRw); v.exRd = 1'(exRd);
    v.memD = 5'(memD); v.memRw = 1'(memRw);
    v.br = 1'(br);     v.z = 1'(z);
    v.st1 = 1'(st1);   v.st3 = 1'(st3);   v.fl = 1'(fl);
    v.fa1 = 2'(fa1);   v.fb1 = 2'(fb1);   v.fa3 = 2'(fa3); v.fb3 = 2'(fb3);
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    fwd_t f;
    @(posedge clock);
    #1;
    reset = v.rst;        id_rs = v.rs;          id_rt = v.rt;        id_uses_rt = v.ur;
    ex_dest = v.exD;      ex_RegWrite = v.exRw;  ex_read_en = v.exRd;
    mem_dest = v.memD;    mem_RegWrite = v.memRw;
    mem_branch = v.br;    mem_zero = v.z;
    @(negedge clock);
    if (sb.size() > 0) begin
      f = sb.pop_front();
      checkOutput($sformatf("row%0d FA(L1)", idx), 32'(fa1), 32'(f.fa1));
      checkOutput($sformatf("row%0d FB(L1)", idx), 32'(fb1), 32'(f.fb1));
      checkOutput($sformatf("row%0d FA(L3)", idx), 32'(fa3), 32'(f.fa3));
      checkOutput($sformatf("row%0d FB(L3)", idx), 32'(fb3), 32'(f.fb3));
    end
    if (v.chk) begin
      checkOutput($sformatf("row%0d pc_write_en(L1)", idx), 32'(pc1), 32'(!v.st1));
      checkOutput($sformatf("row%0d ifid_write_en(L1)", idx), 32'(ifid1), 32'(!v.st1));
      checkOutput($sformatf("row%0d idex_bubble(L1)", idx), 32'(bub1), 32'(v.st1));
      checkOutput($sformatf("row%0d pc_write_en(L3)", idx), 32'(pc3), 32'(!v.st3));
      checkOutput($sformatf("row%0d ifid_write_en(L3)", idx), 32'(ifid3), 32'(!v.st3));
      checkOutput($sformatf("row%0d idex_bubble(L3)", idx), 32'(bub3), 32'(v.st3));
      checkOutput($sformatf("row%0d flushes(L1)", idx), 32'({fi1, fe1, fx1}), 32'({3{v.fl}}));
      checkOutput($sformatf("row%0d flushes(L3)", idx), 32'({fi3, fe3, fx3}), 32'({3{v.fl}}));
      checkOutput($sformatf("row%0d stall_cnt(L1)", idx), 32'(sc1), 32'(expSc1));
      checkOutput($sformatf("row%0d stall_cnt(L3)", idx), 32'(sc3), 32'(expSc3));
      checkOutput($sformatf("row%0d flush_cnt(L1)", idx), 32'(fc1), 32'(expFc1));
      checkOutput($sformatf("row%0d flush_cnt(L3)", idx), 32'(fc3), 32'(expFc3));
    end
    f.fa1 = v.fa1; f.fb1 = v.fb1; f.fa3 = v.fa3; f.fb3 = v.fb3;
    sb.push_back(f);
    if (v.rst) begin
      expSc1 = 0; expSc3 = 0; expFc1 = 0; expFc3 = 0;
    end else begin
`ifdef HAZ_PERF_CNT_EN
      if (v.st1 && expSc1 < 65535) expSc1++;
      if (v.st3 && expSc3 < 15) expSc3++;
      if (v.fl && expFc1 < 65535) expFc1++;
      if (v.fl && expFc3 < 15) expFc3++;
`endif
    end
  endtask

  initial begin
    //                rst chk rs rt ur exD Rw Rd memD Rw br z  st1 st3 fl  fa1 fb1 fa3 fb3
    vecs.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  3, 4, 1, 3,  1, 0, 0,   0, 0, 0, 0,  0,  0,  2,  0,  2,  0));
    vecs.push_back(mk(0, 1,  1, 4, 1, 0,  0, 0, 4,   1, 0, 0, 0,  0,  0,  0,  1,  0,  1));
    vecs.push_back(mk(0, 1,  4, 4, 0, 0,  0, 0, 4,   1, 0, 0, 0,  0,  0,  1,  0,  1,  0));
    vecs.push_back(mk(0, 1,  0, 0, 1, 0,  1, 1, 0,   1, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  7, 7, 1, 7,  1, 0, 7,   1, 0, 0, 0,  0,  0,  2,  2,  2,  2));
    vecs.push_back(mk(0, 1,  8, 9, 1, 6,  1, 1, 9,   1, 0, 0, 0,  0,  0,  0,  1,  0,  1));
    vecs.push_back(mk(0, 1,  3, 0, 0, 3,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    // load-use on rt: L1 one bubble then WB forward, L3 three bubbles
    vecs.push_back(mk(0, 1,  2, 5, 1, 5,  1, 1, 2,   1, 0, 0, 1,  1,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  2, 5, 1, 0,  0, 0, 5,   1, 0, 0, 0,  1,  0,  0,  1,  0,  0));
    vecs.push_back(mk(0, 1,  2, 5, 1, 0,  0, 0, 0,   0, 0, 0, 0,  1,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    // load-use together with taken branch, then untaken branch
    vecs.push_back(mk(0, 1,  5, 5, 1, 5,  1, 1, 5,   1, 1, 1, 0,  0,  1,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 1, 0, 0,  0,  0,  0,  0,  0,  0));
    // taken branch while L3 sits in STALL
    vecs.push_back(mk(0, 1,  2, 5, 1, 5,  1, 1, 2,   1, 0, 0, 1,  1,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 1, 1, 0,  0,  1,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    // reset in the middle of an L3 stall
    vecs.push_back(mk(0, 1,  2, 5, 1, 5,  1, 1, 2,   1, 0, 0, 1,  1,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  1,  0,  0,  0,  0,  0));
    vecs.push_back(mk(1, 0,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));
    // repeated load-use hazards drive the 4-bit L3 stall counter into saturation
    for (int k = 0; k < 6; k++) begin
      vecs.push_back(mk(0, 1, 2, 5, 1, 5, 1, 1, 2, 1, 0, 0, 1, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    end
    vecs.push_back(mk(0, 1,  0, 0, 0, 0,  0, 0, 0,   0, 0, 0, 0,  0,  0,  0,  0,  0,  0));

    for (int i = 0; i < vecs.size(); i++)
      applyStimulus(vecs[i], i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core. It generates the registered forwarding selects FA/FB consumed by the execute stage, and stalls PC and IF/ID on load-use hazards, with a programmable load latency. It also flushes the younger stages when a taken branch resolves in MEM. It sits beside decode and consumes register addresses and control bits from ID, ID/EX, EX/MEM and MEM/WB.

Parameters:
LOAD_LAT, 1, stall cycles inserted per load-use hazard (1..7)
CNT_W, 16, width of performance counters (used only with HAZ_PERF_CNT_EN)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
id_rs  in  5  rs of the instruction in ID
id_rt  in  5  rt of the instruction in ID
id_uses_rt  in  1  ID instruction reads rt as an ALU operand (R-type/branch)
ex_dest  in  5  destination register of the instruction in EX (after RegDst mux)
ex_RegWrite  in  1  EX instruction writes the register file
ex_read_en  in  1  EX instruction is a load
mem_dest  in  5  destination register of the instruction in MEM
mem_RegWrite  in  1  MEM instruction writes the register file
mem_branch  in  1  branch control bit in MEM
mem_zero  in  1  zero flag in MEM
FA  out  2  operand A select for EX: 00 register file, 01 WB data, 10 MEM ALU result
FB  out  2  operand B select for EX, same encoding
pc_write_en  out  1  PC update enable
ifid_write_en  out  1  IF/ID register enable
idex_bubble  out  1  zero the control bits entering ID/EX
flush_ifid  out  1  squash IF/ID
flush_idex  out  1  squash ID/EX
flush_exmem  out  1  squash EX/MEM control bits
stall_cnt  out  CNT_W  stall cycles counted
flush_cnt  out  CNT_W  taken-branch flushes counted

Behaviour:
- Reset: state RUN, stall counter 0, FA=FB=00, stall_cnt=flush_cnt=0. pc_write_en=ifid_write_en=1. All bubble and flush outputs 0.
- branch_taken = mem_branch & mem_zero.
- Flush is combinational in the same cycle: flush_ifid=flush_idex=flush_exmem=branch_taken.
- Load-use hazard (lu): ex_read_en & ex_RegWrite & ex_dest!=0 & (ex_dest==id_rs | (id_uses_rt & ex_dest==id_rt)).
- FSM RUN:
  - If lu & !branch_taken: go to STALL and load counter with LOAD_LAT-1.
  - Outputs this cycle: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
- FSM STALL:
  - Outputs: pc_write_en=0, ifid_write_en=0, idex_bubble=1.
  - Counter decrements each cycle; when it reaches 0, go to RUN.
  - With LOAD_LAT=1, STALL is skipped (RUN to RUN, one bubble total).
- Branch priority: branch_taken in any state forces RUN, clears the counter, and deasserts stall outputs that cycle.
- FA/FB are registered and describe the instruction that enters EX next cycle.
  - next_FA = 10 if ex_RegWrite & ex_dest!=0 & ex_dest==id_rs & !ex_read_en.
  - Else 01 if mem_RegWrite & mem_dest!=0 & mem_dest==id_rs.
  - Else 00.
  - next_FB: same comparisons against id_rt, gated by id_uses_rt.
  - Nearer stage wins when both match.
- If the ID/EX register is bubbled or flushed this cycle, next FA/FB=00.
- Register 0 never forwards or stalls.
- Reset mid-stall: returns to RUN next edge; no residual bubble.

Optional Feature:
HAZ_PERF_CNT_EN:
- Defined: stall_cnt increments every cycle idex_bubble=1. flush_cnt increments every cycle branch_taken=1. Both saturate at all-ones and clear on reset.
- Undefined: both counter outputs are tied to 0 and no counter flops exist.

Decomposition:
- hazard_pkg: fwd_sel_t enum (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10), state_t enum (RUN, STALL), REG_ZERO constant.
- Sub-module fwd_select: combinational compare of one source register against the EX/MEM producers, returning fwd_sel_t. Instantiated twice (A and B).

Test Plan:
- add $3,$1,$2 in EX (ex_dest=3, RegWrite); ID rs=3 -> next cycle FA=10, FB=00, no stall.
- lw $5 in EX (ex_read_en=1, ex_dest=5); ID rt=5, id_uses_rt=1, LOAD_LAT=1 -> one cycle of pc_write_en=0, idex_bubble=1; the following cycle FB=01 with the dependent in EX.
- LOAD_LAT=3, same load-use case -> exactly 3 bubble cycles, then RUN; stall_cnt=3 with HAZ_PERF_CNT_EN.
- Load-use in RUN and mem_branch=mem_zero=1 in the same cycle -> all three flushes=1, pc_write_en=1, no stall, FA=FB=00 next cycle; flush_cnt=1.
- ex_dest=0 with RegWrite and ID rs=0 -> FA=00, no stall. ex_dest=mem_dest=7 and ID rs=7 -> FA=10 (nearer wins).
- reset asserted during the second STALL cycle (LOAD_LAT=3) -> next cycle pc_write_en=1, idex_bubble=0, counters 0.
